// File: rtl/cc1200_spi_qregs_if.sv
// APB bus bundle between a CPU-side master and the CC1200 SPI queue register block.
interface cc1200_spi_qregs_if;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/cc1200_spi_qregs.sv
// APB register front-end for a CC1200 SPI engine: TX/RX word queues, a launch sequencer,
// clock divider, GPIO and a small W1C interrupt block.
module cc1200_spi_qregs #(
  parameter int GPIO_W   = 4,
  parameter int DEPTH    = 4,
  parameter int CLKDIV_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  cc1200_spi_qregs_if.slave   apb,
  output logic                start,
  input  logic                busy,
  output logic [31:0]         data_out,
  output logic [3:0]          wr,
  input  logic [31:0]         data_in,
  output logic [CLKDIV_W-1:0] clock_div,
  output logic [GPIO_W-1:0]   gpio_oe,
  output logic [GPIO_W-1:0]   gpio_out,
  input  logic [GPIO_W-1:0]   gpio_in,
  output logic                irq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              r_state, w_stateNext;
  logic                r_pready;
  logic                r_en;
  logic [3:0]          r_wr;
  logic [CLKDIV_W-1:0] r_clkDiv;
  logic [GPIO_W-1:0]   r_gpioOe, r_gpioOut;
  logic [2:0]          r_irqStat, r_irqEn;
  logic [31:0]         r_dataOut;
  logic [3:0]          r_wrOut;

  logic [35:0]         r_txMem [DEPTH];
  logic [31:0]         r_rxMem [DEPTH];
  logic [PTR_W-1:0]    r_txRd, r_txWr, r_rxRd, r_rxWr;
  logic [LVL_W-1:0]    r_txLvl, r_rxLvl;

  logic        w_acc, w_ok, w_err, w_mapped, w_ro;
  logic [31:0] w_rdata, w_status;
  logic        w_txFull, w_txEmpty, w_rxFull, w_rxEmpty;
  logic        w_txPush, w_txPop, w_rxPush, w_rxPop, w_flush;
  logic        w_capture, w_txOvf, w_rxOvf;
  logic [2:0]  w_irqSet, w_irqClr;

  assign w_txFull  = (r_txLvl == LVL_W'(DEPTH));
  assign w_txEmpty = (r_txLvl == '0);
  assign w_rxFull  = (r_rxLvl == LVL_W'(DEPTH));
  assign w_rxEmpty = (r_rxLvl == '0);

  assign w_status = {11'b0, 5'(r_rxLvl), 3'b0, 5'(r_txLvl), 3'b0,
                     w_rxFull, w_rxEmpty, w_txEmpty, w_txFull, (r_state != IDLE)};

  // One wait state: pready rises the cycle after the access phase starts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_pready <= 1'b0;
    else       r_pready <= apb.psel & apb.penable & ~r_pready;
  end

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    w_ro     = 1'b0;
    case (apb.paddr)
      8'h00: w_rdata = {31'b0, r_en};
      8'h04: begin w_rdata = w_status; w_ro = 1'b1; end
      8'h08: w_rdata = '0;
      8'h0C: begin w_rdata = w_rxEmpty ? 32'b0 : r_rxMem[r_rxRd]; w_ro = 1'b1; end
      8'h10: w_rdata = {28'b0, r_wr};
      8'h14: w_rdata = 32'(r_clkDiv);
      8'h18: w_rdata = 32'(r_gpioOe);
      8'h1C: w_rdata = 32'(r_gpioOut);
      8'h20: begin w_rdata = 32'(gpio_in); w_ro = 1'b1; end
      8'h24: w_rdata = {29'b0, r_irqStat};
      8'h28: w_rdata = {29'b0, r_irqEn};
      default: w_mapped = 1'b0;
    endcase
  end

  assign w_err = ~w_mapped | (apb.pwrite & w_ro)
               | (apb.pwrite & (apb.paddr == 8'h08) & w_txFull)
               | (~apb.pwrite & (apb.paddr == 8'h0C) & w_rxEmpty);
  assign w_acc = apb.psel & apb.penable & r_pready;
  assign w_ok  = w_acc & ~w_err;

  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pready & w_err;
  assign apb.prdata  = (r_pready & ~apb.pwrite) ? w_rdata : 32'b0;

  assign w_txPush = w_ok & apb.pwrite & (apb.paddr == 8'h08);
  assign w_txOvf  = w_acc & apb.pwrite & (apb.paddr == 8'h08) & w_txFull;
  assign w_rxPop  = w_ok & ~apb.pwrite & (apb.paddr == 8'h0C);
  assign w_flush  = w_ok & apb.pwrite & (apb.paddr == 8'h00) & apb.pwdata[1];
  assign w_rxPush = w_capture & ~w_rxFull;
  assign w_rxOvf  = w_capture & w_rxFull;
  assign w_irqSet = {w_rxOvf, w_txOvf, w_capture};
  assign w_irqClr = (w_ok & apb.pwrite & (apb.paddr == 8'h24)) ? apb.pwdata[2:0] : 3'b0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en      <= 1'b0;
      r_wr      <= '0;
      r_clkDiv  <= '0;
      r_gpioOe  <= '0;
      r_gpioOut <= '0;
      r_irqEn   <= '0;
      r_irqStat <= '0;
    end else begin
      if (w_ok && apb.pwrite) begin
        case (apb.paddr)
          8'h00: r_en      <= apb.pwdata[0];
          8'h10: r_wr      <= apb.pwdata[3:0];
          8'h14: r_clkDiv  <= apb.pwdata[CLKDIV_W-1:0];
          8'h18: r_gpioOe  <= apb.pwdata[GPIO_W-1:0];
          8'h1C: r_gpioOut <= apb.pwdata[GPIO_W-1:0];
          8'h28: r_irqEn   <= apb.pwdata[2:0];
          default: ;
        endcase
      end
      // Hardware set wins over a same-cycle software clear.
      r_irqStat <= (r_irqStat & ~w_irqClr) | w_irqSet;
    end
  end

  always_ff @(posedge clk) begin
    if (w_txPush) r_txMem[r_txWr] <= {r_wr, apb.pwdata};
    if (w_rxPush) r_rxMem[r_rxWr] <= data_in;
  end

  // Flush collapses read pointers onto write pointers; a capture in the same cycle survives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_txRd  <= '0;
      r_txWr  <= '0;
      r_txLvl <= '0;
      r_rxRd  <= '0;
      r_rxWr  <= '0;
      r_rxLvl <= '0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + PTR_W'(1);
      if (w_rxPush) r_rxWr <= r_rxWr + PTR_W'(1);
      if (w_flush) begin
        r_txRd  <= r_txWr;
        r_txLvl <= '0;
        r_rxRd  <= r_rxWr;
        r_rxLvl <= LVL_W'(w_rxPush);
      end else begin
        if (w_txPop) r_txRd <= r_txRd + PTR_W'(1);
        if (w_rxPop) r_rxRd <= r_rxRd + PTR_W'(1);
        r_txLvl <= r_txLvl + LVL_W'(w_txPush) - LVL_W'(w_txPop);
        r_rxLvl <= r_rxLvl + LVL_W'(w_rxPush) - LVL_W'(w_rxPop);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dataOut <= '0;
      r_wrOut   <= '0;
    end else if (w_txPop) begin
      {r_wrOut, r_dataOut} <= r_txMem[r_txRd];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:      if (r_en && !w_txEmpty) w_stateNext = LAUNCH;
      LAUNCH:    w_stateNext = WAIT_BUSY;
      WAIT_BUSY: if (busy) w_stateNext = WAIT_DONE;
      WAIT_DONE: if (!busy) w_stateNext = IDLE;
      default:   w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    start     = (r_state == LAUNCH);
    w_txPop   = (r_state == IDLE) & r_en & ~w_txEmpty;
    w_capture = (r_state == WAIT_DONE) & ~busy;
  end

  assign data_out  = r_dataOut;
  assign wr        = r_wrOut;
  assign clock_div = r_clkDiv;
  assign gpio_oe   = r_gpioOe;
  assign gpio_out  = r_gpioOut;
  assign irq       = |(r_irqStat & r_irqEn);
endmodule
